// File: rtl/sign_window_stats_pkg.sv
// Shared types and width helpers for the sign window statistics block.
// Optional run tracking is enabled with SIGN_WINDOW_STATS_RUN_EN.
package sign_window_stats_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int sum_w(input int width, input int window);
    return width + $clog2(window);
  endfunction

  function automatic int sign_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/sign_run_tracker.sv
// Tracks the current and longest run of negative samples in a window.
// Built only when SIGN_WINDOW_STATS_RUN_EN is defined.
module sign_run_tracker
  import sign_window_stats_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         accept,
  input  logic         sign,
  output logic [W-1:0] max_next
);

  logic [W-1:0] cur_run;
  logic [W-1:0] max_run;
  logic [W-1:0] cur_next;

  // max_next already includes the sample accepted this cycle
  always_comb begin
    cur_next = cur_run;
    max_next = max_run;
    if (start) begin
      cur_next = accept ? W'(sign) : '0;
      max_next = cur_next;
    end else if (accept) begin
      cur_next = sign ? cur_run + W'(1) : '0;
      max_next = (cur_next > max_run) ? cur_next : max_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_run <= '0;
      max_run <= '0;
    end else begin
      cur_run <= cur_next;
      max_run <= max_next;
    end
  end

endmodule

// File: rtl/sign_window_stats.sv
// Per-window negative/non-negative counts and signed sum of a sample stream.
// Define SIGN_WINDOW_STATS_RUN_EN to report the longest negative run.
module sign_window_stats
  import sign_window_stats_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int WINDOW = 16,
  localparam int CNT_W  = cnt_w(WINDOW),
  localparam int SUM_W  = sum_w(WIDTH, WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [CNT_W-1:0] neg_count,
  output logic [CNT_W-1:0] pos_count,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] max_neg_run
);

  localparam int SB = sign_bit(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] neg_acc;
  logic [CNT_W-1:0] pos_acc;
  logic [SUM_W-1:0] sum_acc;

  logic             accept;
  logic             last;
  logic             sign;
  logic [SUM_W-1:0] ext;
  logic [CNT_W-1:0] neg_next;
  logic [CNT_W-1:0] pos_next;
  logic [SUM_W-1:0] sum_next;

  // clear wins over a simultaneous sample
  assign accept = in_valid & ~clear;
  assign last   = accept & (state == ACC) &
                  (cnt == CNT_W'(WINDOW - 1));
  assign sign   = in_data[SB];
  assign ext    = {{(SUM_W - WIDTH){sign}}, in_data};

  assign neg_next = neg_acc + CNT_W'(sign);
  assign pos_next = pos_acc + CNT_W'(~sign);
  assign sum_next = sum_acc + ext;

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) next_state = ACC;
        ACC:  if (last)     next_state = IDLE;
        default:            next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      neg_acc   <= '0;
      pos_acc   <= '0;
      sum_acc   <= '0;
      out_valid <= 1'b0;
      neg_count <= '0;
      pos_count <= '0;
      sum       <= '0;
    end else begin
      state     <= next_state;
      out_valid <= last;
      if (clear) begin
        cnt     <= '0;
        neg_acc <= '0;
        pos_acc <= '0;
        sum_acc <= '0;
      end else if (last) begin
        cnt       <= '0;
        neg_acc   <= '0;
        pos_acc   <= '0;
        sum_acc   <= '0;
        neg_count <= neg_next;
        pos_count <= pos_next;
        sum       <= sum_next;
      end else if (accept) begin
        cnt     <= cnt + CNT_W'(1);
        neg_acc <= neg_next;
        pos_acc <= pos_next;
        sum_acc <= sum_next;
      end
    end
  end

`ifdef SIGN_WINDOW_STATS_RUN_EN
  logic             run_start;
  logic [CNT_W-1:0] run_max;

  // first sample of a window restarts the run so runs never span windows
  assign run_start = clear | (accept & (state == IDLE));

  sign_run_tracker #(
    .W (CNT_W)
  ) u_run (
    .clk      (clk),
    .rst      (rst),
    .start    (run_start),
    .accept   (accept),
    .sign     (sign),
    .max_next (run_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_neg_run <= '0;
    end else if (last) begin
      max_neg_run <= run_max;
    end
  end
`else
  assign max_neg_run = '0;
`endif

endmodule
